// File: rtl/my_xor_pkg.sv
// Shared constants and helpers for the my_xor compare/diff element.
package my_xor_pkg;

   // Default width of the differing-bit accumulator.
   localparam int CNT_W_DEF = 16;

   // Bits needed to hold a population count of a w-bit vector (0..w).
   function automatic int pc_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/my_xor_if.sv
// Operand/result bundle for my_xor. The master drives operands, the slave
// (the XOR unit) returns the diff, its parity and the running diff count.
interface my_xor_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             clr_cnt;
   logic [WIDTH-1:0] out;
   logic             parity;
   logic             out_valid;
   logic [CNT_W-1:0] diff_count;

   modport master (
      output a, b, in_valid, clr_cnt,
      input  out, parity, out_valid, diff_count
   );

   modport slave (
      input  a, b, in_valid, clr_cnt,
      output out, parity, out_valid, diff_count
   );
endinterface

// File: rtl/my_xor_popcount.sv
// Combinational population count of a^b; feeds the diff accumulator.
module my_xor_popcount
   import my_xor_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int PCW   = pc_width(WIDTH)
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [PCW-1:0]   o_cnt
);

   logic [WIDTH-1:0] w_x;

   assign w_x = i_a ^ i_b;

   // Sum the set bits of the difference vector.
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_cnt = o_cnt + PCW'(w_x[i]);
      end
   end

endmodule

// File: rtl/my_xor.sv
// Bitwise XOR unit with optional output register, valid handshake, parity
// of the difference and a saturating count of differing bits.
// WIDTH/CNT_W must match the parameters of the connected my_xor_if.
module my_xor
   import my_xor_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int REGISTERED = 1
) (
   input  logic     clk,
   input  logic     rst,
   my_xor_if.slave  bus
);

   localparam int PCW   = pc_width(WIDTH);
   // Sum is wide enough for either operand plus a carry, so the
   // saturation compare never sees a wrapped value.
   localparam int SUM_W = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] w_x;
   logic             w_par;
   logic [PCW-1:0]   w_pc;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] r_cnt;

   assign w_x   = bus.a ^ bus.b;
   assign w_par = ^w_x;

   my_xor_popcount #(
      .WIDTH (WIDTH),
      .PCW   (PCW)
   ) u_popcount (
      .i_a   (bus.a),
      .i_b   (bus.b),
      .o_cnt (w_pc)
   );

   assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_pc);

   // Accumulate differing bits; clear beats an accepted input, saturate at max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (bus.clr_cnt) begin
         r_cnt <= '0;
      end else if (bus.in_valid) begin
         r_cnt <= (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_sum);
      end
   end

   assign bus.diff_count = r_cnt;

   if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] r_out;
      logic             r_par;
      logic             r_vld;

      // Capture result on accepted input, hold otherwise; valid tracks input.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_out <= '0;
            r_par <= 1'b0;
            r_vld <= 1'b0;
         end else begin
            r_vld <= bus.in_valid;
            if (bus.in_valid) begin
               r_out <= w_x;
               r_par <= w_par;
            end
         end
      end

      assign bus.out       = r_out;
      assign bus.parity    = r_par;
      assign bus.out_valid = r_vld;
   end else begin : g_comb
      // Zero-latency path: result and valid follow the inputs directly.
      assign bus.out       = w_x;
      assign bus.parity    = w_par;
      assign bus.out_valid = bus.in_valid;
   end

endmodule

// File: tb/tb_my_xor.sv
// Directed testbench for my_xor: four instances cover the 1-bit gate,
// 8-bit registered, 8-bit with a 4-bit saturating counter, and 8-bit
// combinational configurations.
module tb_my_xor;

   logic clk;
   logic rst;

   int n_chk;
   int n_err;

   my_xor_if #(.WIDTH(1), .CNT_W(16)) if1 ();
   my_xor_if #(.WIDTH(8), .CNT_W(16)) if8 ();
   my_xor_if #(.WIDTH(8), .CNT_W(4))  ifs ();
   my_xor_if #(.WIDTH(8), .CNT_W(16)) ifc ();

   my_xor #(.WIDTH(1), .CNT_W(16), .REGISTERED(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   my_xor #(.WIDTH(8), .CNT_W(16), .REGISTERED(1)) u8 (.clk(clk), .rst(rst), .bus(if8));
   my_xor #(.WIDTH(8), .CNT_W(4),  .REGISTERED(1)) us (.clk(clk), .rst(rst), .bus(ifs));
   my_xor #(.WIDTH(8), .CNT_W(16), .REGISTERED(0)) uc (.clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] va, vb;
   int          exp1 [4];

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      if1.a = '0; if1.b = '0; if1.in_valid = 1'b0; if1.clr_cnt = 1'b0;
      if8.a = '0; if8.b = '0; if8.in_valid = 1'b0; if8.clr_cnt = 1'b0;
      ifs.a = '0; ifs.b = '0; ifs.in_valid = 1'b0; ifs.clr_cnt = 1'b0;
      ifc.a = '0; ifc.b = '0; ifc.in_valid = 1'b0; ifc.clr_cnt = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_out8",  32'(if8.out),        32'h0);
      chk("rst_par8",  32'(if8.parity),     32'h0);
      chk("rst_vld8",  32'(if8.out_valid),  32'h0);
      chk("rst_cnt8",  32'(if8.diff_count), 32'h0);
      chk("rst_out1",  32'(if1.out),        32'h0);
      chk("rst_cnt_s", 32'(ifs.diff_count), 32'h0);
      #2 rst = 1'b0;

      // First accepted input of zeros
      if8.a = 8'h00; if8.b = 8'h00; if8.in_valid = 1'b1;
      tick();
      chk("zero_out",  32'(if8.out),        32'h0);
      chk("zero_par",  32'(if8.parity),     32'h0);
      chk("zero_vld",  32'(if8.out_valid),  32'h1);
      chk("zero_cnt",  32'(if8.diff_count), 32'h0);
      if8.in_valid = 1'b0;

      // WIDTH=1: operands truncated to bit 0
      exp1[0] = 0; exp1[1] = 1; exp1[2] = 0; exp1[3] = 1;
      if1.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin va = 32'd0; vb = 32'd0; end
            1: begin va = 32'd3; vb = 32'd0; end
            2: begin va = 32'd3; vb = 32'd5; end
            default: begin va = 32'd4; vb = 32'd5; end
         endcase
         if1.a = va[0:0];
         if1.b = vb[0:0];
         tick();
         chk($sformatf("w1_out%0d", i), 32'(if1.out), 32'(exp1[i]));
         chk($sformatf("w1_par%0d", i), 32'(if1.parity), 32'(exp1[i]));
      end
      if1.in_valid = 1'b0;
      chk("w1_cnt", 32'(if1.diff_count), 32'd2);

      // WIDTH=8 diff and parity
      if8.a = 8'hF0; if8.b = 8'h3C; if8.in_valid = 1'b1;
      tick();
      chk("w8_out_cc", 32'(if8.out),        32'hCC);
      chk("w8_par_cc", 32'(if8.parity),     32'h0);
      chk("w8_cnt_4",  32'(if8.diff_count), 32'd4);
      if8.a = 8'h01; if8.b = 8'h00;
      tick();
      chk("w8_out_01", 32'(if8.out),        32'h01);
      chk("w8_par_01", 32'(if8.parity),     32'h1);
      chk("w8_cnt_5",  32'(if8.diff_count), 32'd5);

      // Hold with in_valid low while operands wiggle
      if8.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if8.a = 8'(8'h11 * (i + 1));
         if8.b = 8'(8'h5A + i);
         tick();
         chk($sformatf("hold_out%0d", i), 32'(if8.out),        32'h01);
         chk($sformatf("hold_par%0d", i), 32'(if8.parity),     32'h1);
         chk($sformatf("hold_cnt%0d", i), 32'(if8.diff_count), 32'd5);
         chk($sformatf("hold_vld%0d", i), 32'(if8.out_valid),  32'h0);
      end

      // Saturation with a 4-bit counter
      ifs.a = 8'hFF; ifs.b = 8'h00; ifs.in_valid = 1'b1;
      tick();
      chk("sat_cnt8",  32'(ifs.diff_count), 32'd8);
      chk("sat_out",   32'(ifs.out),        32'hFF);
      tick();
      chk("sat_cnt15", 32'(ifs.diff_count), 32'd15);
      tick();
      chk("sat_hold15", 32'(ifs.diff_count), 32'd15);
      ifs.clr_cnt = 1'b1;
      tick();
      chk("clr_wins",  32'(ifs.diff_count), 32'd0);
      ifs.clr_cnt = 1'b0; ifs.in_valid = 1'b0;

      // Combinational configuration: no edge needed for out/valid
      ifc.a = 8'hF0; ifc.b = 8'h3C; ifc.in_valid = 1'b1;
      #1;
      chk("comb_out", 32'(ifc.out),       32'hCC);
      chk("comb_par", 32'(ifc.parity),    32'h0);
      chk("comb_vld", 32'(ifc.out_valid), 32'h1);
      tick();
      chk("comb_cnt", 32'(ifc.diff_count), 32'd4);
      ifc.a = 8'h07; ifc.in_valid = 1'b0;
      #1;
      chk("comb_out2", 32'(ifc.out),       32'h3B);
      chk("comb_par2", 32'(ifc.parity),    32'h1);
      chk("comb_vld0", 32'(ifc.out_valid), 32'h0);

      // Async reset between edges
      #2 rst = 1'b1;
      #1;
      chk("arst_out",  32'(if8.out),        32'h0);
      chk("arst_par",  32'(if8.parity),     32'h0);
      chk("arst_cnt",  32'(if8.diff_count), 32'h0);
      chk("arst_cntc", 32'(ifc.diff_count), 32'h0);
      chk("arst_cnt1", 32'(if1.diff_count), 32'h0);
      #1 rst = 1'b0;

      // Processing resumes normally after release
      if8.a = 8'h0A; if8.b = 8'h05; if8.in_valid = 1'b1;
      tick();
      chk("post_out", 32'(if8.out),        32'h0F);
      chk("post_par", 32'(if8.parity),     32'h0);
      chk("post_vld", 32'(if8.out_valid),  32'h1);
      chk("post_cnt", 32'(if8.diff_count), 32'd4);
      if8.in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
